// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1/8E1/8O1 UART receiver driven by the baud
// generator's oversample tick. Delivers each byte with a one-cycle strobe
// and per-frame framing/parity error flags.
//
// Handshake: data_valid is a one-clk strobe with no ready/backpressure;
// data_out, frame_err and parity_err change only in the cycle data_valid is
// high and hold until the next frame, so the consumer captures on data_valid.
module uart_rx_core #(
    parameter int SAMPLE = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx,
    input  logic       tick,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(SAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(SAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(SAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          sync1, rx_s;
    logic [CW-1:0] s_cnt, s_cnt_n;
    logic [2:0]    b_cnt, b_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_acc, par_acc_n;
    logic          pen_l, pen_l_n;
    logic          pod_l, pod_l_n;
    logic          perr, perr_n;
    logic          load;

    // Two-stage synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and datapath-next logic; all decisions use rx_s.
    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        b_cnt_n   = b_cnt;
        shreg_n   = shreg;
        par_acc_n = par_acc;
        pen_l_n   = pen_l;
        pod_l_n   = pod_l;
        perr_n    = perr;
        load      = 1'b0;
        case (state)
            IDLE: begin
                // Level detect: a tick in this same cycle is not counted.
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == HALF_M1) begin
                        s_cnt_n = '0;
                        if (!rx_s) begin
                            // Start bit confirmed at its centre; freeze frame format.
                            state_n   = DATA;
                            b_cnt_n   = '0;
                            shreg_n   = '0;
                            par_acc_n = 1'b0;
                            perr_n    = 1'b0;
                            pen_l_n   = parity_en;
                            pod_l_n   = parity_odd;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == LAST) begin
                        shreg_n   = {rx_s, shreg[7:1]};
                        par_acc_n = par_acc ^ rx_s;
                        s_cnt_n   = '0;
                        if (b_cnt == 3'd7) state_n = pen_l ? PARITY : STOP;
                        else               b_cnt_n = b_cnt + 3'd1;
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s_cnt == LAST) begin
                        perr_n  = par_acc ^ rx_s ^ pod_l;
                        s_cnt_n = '0;
                        state_n = STOP;
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is caught.
                        load    = 1'b1;
                        s_cnt_n = '0;
                        state_n = IDLE;
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath registers: counters, shift register, parity and latched format.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s_cnt   <= '0;
            b_cnt   <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            pen_l   <= 1'b0;
            pod_l   <= 1'b0;
            perr    <= 1'b0;
        end else begin
            s_cnt   <= s_cnt_n;
            b_cnt   <= b_cnt_n;
            shreg   <= shreg_n;
            par_acc <= par_acc_n;
            pen_l   <= pen_l_n;
            pod_l   <= pod_l_n;
            perr    <= perr_n;
        end
    end

    // Output registers: update byte and flags together with the valid strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            data_valid <= load;
            if (load) begin
                data_out   <= shreg;
                frame_err  <= ~rx_s;
                parity_err <= perr;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames at SAMPLE=16, tick every 4 clk (64 clk/bit).
module tb_uart_rx_core;

    logic       clk;
    logic       n_rst;
    logic       rx;
    logic       tick;
    logic       parity_en;
    logic       parity_odd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    longint cycle = 0;
    logic [9:0] exp_q[$];
    longint     valid_t[$];

    uart_rx_core #(.SAMPLE(16)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx         (rx),
        .tick       (tick),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // ---- clock / tick / cycle counter ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    int tick_div = 0;
    initial tick = 1'b0;
    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        tick = (tick_div == 0);
    end

    // ---- checking ----
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- scoreboard: compares each strobe against the expected queue ----
    always @(negedge clk) begin
        if (n_rst && data_valid) begin
            n_valid++;
            valid_t.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("valid_without_expect", 32'(exp_q.size()), 32'd1);
            end else begin
                check("frame", {22'd0, frame_err, parity_err, data_out}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // ---- driver tasks ----
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
        exp_q.push_back({fe, pe, d});
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                              input logic stop_bit, input logic chk_busy);
        if (chk_busy) begin
            rx = 1'b0;
            repeat (2) @(negedge clk);
            check("busy_before_3clk", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("busy_at_3clk", {31'd0, busy}, 32'd1);
            repeat (61) @(negedge clk);
        end else begin
            drive_bit(1'b0, 64);
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
        if (par_on) drive_bit(par_bit, 64);
        if (stop_bit) begin
            drive_bit(1'b1, 64);
        end else begin
            // Low across the stop sample point, then high before re-validation.
            drive_bit(1'b0, 40);
            drive_bit(1'b1, 24);
        end
    endtask

    // ---- stimulus ----
    initial begin
        int base;
        int k;
        longint diff;
        rx = 1'b1;
        n_rst = 1'b0;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data_out",   {24'd0, data_out}, 32'h00);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_frame_err",  {31'd0, frame_err}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);

        // 1: clean 8N1 frame
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1, 64);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        check("t1_valid_count", n_valid, 32'd1);

        // 2: glitch shorter than half a bit
        base = n_valid;
        drive_bit(1'b0, 20);
        check("t2_busy_during_glitch", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        for (k = 0; k < 32 && busy; k++) @(negedge clk);
        check("t2_busy_fall", {31'd0, busy}, 32'd0);
        drive_bit(1'b1, 64);
        check("t2_no_valid", n_valid, base);
        check("t2_data_held", {24'd0, data_out}, 32'hA5);

        // 3: bad stop bit, then a clean frame
        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 128);
        expect_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 64);

        // 4: parity (0x07 has three ones)
        parity_en = 1'b1;
        parity_odd = 1'b0;
        expect_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 64);
        expect_frame(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 64);
        parity_odd = 1'b1;
        expect_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 64);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // 5: back-to-back frames with no idle gap
        base = valid_t.size();
        expect_frame(8'h55, 1'b0, 1'b0);
        expect_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 64);
        check("t5_two_pulses", valid_t.size() - base, 32'd2);
        if (valid_t.size() >= base + 2) begin
            diff = valid_t[base + 1] - valid_t[base];
            check("t5_spacing_640", {31'd0, (diff >= 636 && diff <= 644)}, 32'd1);
        end

        // 6: reset during bit 4 of 0xF0 (bit 4 is 1, line stays high)
        drive_bit(1'b0, 64);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 64);
        drive_bit(1'b1, 32);
        n_rst = 1'b0;
        #1;
        check("t6_rst_data_out",   {24'd0, data_out}, 32'h00);
        check("t6_rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("t6_rst_frame_err",  {31'd0, frame_err}, 32'd0);
        check("t6_rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("t6_rst_busy",       {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        drive_bit(1'b1, 32 + 64 * 4 + 64);
        expect_frame(8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 128);

        // ---- final report ----
        check("pending_expects", exp_q.size(), 32'd0);
        check("total_valid", n_valid, 32'd9);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Oversampling UART receiver that sits directly downstream of the baud generator in the soda-machine UART path. It consumes the generator's oversample `tick` and the raw serial line, recovers 8N1 or 8E1/8O1 frames (LSB first), and presents each received byte with a single-cycle valid strobe and per-frame error flags to the command decoder.

## Interface
Parameters:
- `SAMPLE`, 16, oversampling factor (ticks per bit). Even, 4–254. Must match the `sample` value driven into the baud generator.

Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `rx`  in  1  raw serial input, asynchronous to `clk`, idle high
- `tick`  in  1  one-`clk` pulse at baud×`SAMPLE` from the baud generator
- `parity_en`  in  1  1 = a parity bit follows the 8 data bits
- `parity_odd`  in  1  1 = odd parity, 0 = even; ignored when `parity_en`=0
- `data_out`  out  8  last received byte; held until the next frame completes
- `data_valid`  out  1  one-`clk` pulse when `data_out` and the error flags update
- `frame_err`  out  1  stop bit sampled low; updates with `data_valid`
- `parity_err`  out  1  parity mismatch; 0 when parity is disabled; updates with `data_valid`
- `busy`  out  1  1 while state ≠ IDLE

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`). Both FFs reset to 1. All decisions use `rx_s`.
- Counters:
  - `s_cnt`: tick counter, 0..`SAMPLE`-1, width ceil(log2(`SAMPLE`)).
  - `b_cnt`: 0..7.
  - `shreg`: 8 bits, right-shifting; each new bit enters at bit 7.
  - `par_acc`: XOR of the data bits.
- States and transitions:
  - IDLE: if `rx_s`=0, go to START with `s_cnt`=0. Level-detected, so no tick is required.
  - START: on each tick, `s_cnt`++.
    - At `s_cnt`=`SAMPLE`/2-1, mid start bit: if `rx_s`=0, go to DATA with `s_cnt`=0 and `b_cnt`=0, and latch `parity_en`/`parity_odd`.
    - Otherwise this is a false start: return to IDLE with no output.
  - DATA: on each tick at `s_cnt`=`SAMPLE`-1:
    - sample `rx_s` into `shreg` and `par_acc`, set `s_cnt`=0.
    - if `b_cnt`=7, go to PARITY when the latched `parity_en`=1, else STOP. Otherwise `b_cnt`++.
    - On other ticks, `s_cnt`++.
  - PARITY: at `s_cnt`=`SAMPLE`-1, sample the parity bit.
    - Error when (`par_acc` ^ bit ^ latched `parity_odd`) ≠ 0.
    - Then go to STOP with `s_cnt`=0.
  - STOP: at `s_cnt`=`SAMPLE`-1, mid stop bit:
    - `data_out`←`shreg`, `frame_err`←~`rx_s`, `parity_err`←computed value, `data_valid`←1.
    - Go to IDLE. This leaves half a bit to catch a back-to-back start edge.
- Changes to `parity_en`/`parity_odd` mid-frame do not affect the current frame.
- A frame with `frame_err`=1 still delivers its byte.
- If `rx_s` is still low on return to IDLE (break or bad stop bit), the block re-enters START and repeats the START validation normally.
- No backpressure. The consumer must capture on `data_valid`.

## Timing
- Reset values:
  - `data_out`=0x00, `data_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - State IDLE, all counters 0, sync FFs 1.
- `busy` rises 3 `clk` after the `rx` falling edge: 2 sync stages plus the IDLE→START register.
- Sampling points fall at (`SAMPLE`/2 + k·`SAMPLE`) ticks after start detection, k=1..9 (8N1) or 1..10 (parity on). Error is ±1 tick plus sync delay.
- `data_valid` is high exactly one `clk`: the cycle after the tick that samples the stop bit. `busy` falls in that same cycle.
- Asserting `n_rst` mid-frame aborts immediately to the reset values. The next complete frame after release is received correctly.
- `tick` arriving on the same `clk` as the IDLE→START transition is not counted.

## Test plan
Common setup: `SAMPLE`=16, `tick` every 4 `clk`, bit period 64 `clk`.
1. Frame 0xA5, no parity, stop=1 -> exactly one `data_valid` pulse, `data_out`=0xA5, `frame_err`=0, `parity_err`=0, `busy` back to 0.
2. `rx` low for 5 ticks then high (glitch) -> no `data_valid`, `busy` returns to 0 within 8 ticks, `data_out` unchanged.
3. Frame 0x3C with stop bit driven 0 -> `data_valid`, `data_out`=0x3C, `frame_err`=1. Then a clean frame 0x11 -> `frame_err`=0.
4. `parity_en`=1, `parity_odd`=0, byte 0x07 with parity bit 1 -> `parity_err`=0. Repeat with parity bit 0 -> `parity_err`=1. Repeat with `parity_odd`=1 and parity bit 0 -> `parity_err`=0.
5. Back-to-back frames 0x55 then 0xAA with no idle gap -> two `data_valid` pulses about 640 `clk` apart, values 0x55 then 0xAA, no errors.
6. `n_rst` pulsed low during bit 4 of 0xF0 -> all outputs at reset values. The next frame 0x0F yields `data_out`=0x0F with no errors.
